// File: rtl/axis_dmux_sched.sv
// rtl/axis_dmux_sched.sv - frame-aware select/drop/enable scheduler for a 2-port AXI4-Stream demux
// Steering decisions change only between frames; fixed or weighted round-robin with saturating stats.
module axis_dmux_sched #(
  parameter int WEIGHT_WIDTH = 4,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mon_tvalid,
  input  logic                    mon_tready,
  input  logic                    mon_tlast,
  input  logic                    cfg_enable,
  input  logic                    cfg_mode,
  input  logic                    cfg_port,
  input  logic [1:0]              cfg_port_en,
  input  logic [WEIGHT_WIDTH-1:0] cfg_weight0,
  input  logic [WEIGHT_WIDTH-1:0] cfg_weight1,
  input  logic                    stat_clear,
  output logic                    demux_enable,
  output logic                    demux_drop,
  output logic                    demux_select,
  output logic                    busy,
  output logic [COUNT_WIDTH-1:0]  stat_frames0,
  output logic [COUNT_WIDTH-1:0]  stat_frames1,
  output logic [COUNT_WIDTH-1:0]  stat_drops
);

  typedef enum logic [1:0] {IDLE, ARMED, FRAME} state_t;

  state_t                  state, state_nxt;
  logic                    beat, eof, frame_done;
  logic                    load;
  logic                    sel_q, drop_q, rr_port;
  logic [WEIGHT_WIDTH-1:0] turn_cnt;
  logic                    sel_n, drop_n, rr_n;
  logic [WEIGHT_WIDTH-1:0] turn_n;
  logic                    elig0, elig1;
  logic [WEIGHT_WIDTH-1:0] cur_w;
  logic [WEIGHT_WIDTH:0]   turn_inc;

  assign beat       = mon_tvalid & mon_tready;
  assign eof        = beat & mon_tlast;
  assign frame_done = eof & (state != IDLE);

  assign demux_select = sel_q;
  assign demux_drop   = drop_q;

  // load marks a frame boundary: the only edges where config is taken and the decision may move.
  always_comb begin
    state_nxt    = state;
    demux_enable = 1'b0;
    busy         = 1'b0;
    load         = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_enable) begin
          state_nxt = ARMED;
          load      = 1'b1;
        end
      end
      ARMED: begin
        demux_enable = 1'b1;
        if (beat && !mon_tlast) begin
          state_nxt = FRAME;
        end else begin
          load = 1'b1;
          if (!cfg_enable) state_nxt = IDLE;
        end
      end
      FRAME: begin
        demux_enable = 1'b1;
        busy         = 1'b1;
        if (eof) begin
          load      = 1'b1;
          state_nxt = cfg_enable ? ARMED : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    elig0    = cfg_port_en[0] & (|cfg_weight0);
    elig1    = cfg_port_en[1] & (|cfg_weight1);
    cur_w    = rr_port ? cfg_weight1 : cfg_weight0;
    turn_inc = {1'b0, turn_cnt} + 1'b1;
    rr_n     = rr_port;
    turn_n   = turn_cnt;
    sel_n    = sel_q;
    drop_n   = drop_q;
    if (cfg_mode) begin
      // Only frames actually delivered consume the current port's turn.
      if (eof && !drop_q) begin
        if (turn_inc >= {1'b0, cur_w}) begin
          turn_n = '0;
          if (rr_port ? elig0 : elig1) rr_n = ~rr_port;
        end else begin
          turn_n = turn_inc[WEIGHT_WIDTH-1:0];
        end
      end
      if (!(rr_n ? elig1 : elig0) && (rr_n ? elig0 : elig1)) begin
        rr_n   = ~rr_n;
        turn_n = '0;
      end
      sel_n  = (elig0 | elig1) ? rr_n : sel_q;
      drop_n = ~(elig0 | elig1);
    end else begin
      sel_n  = cfg_port;
      drop_n = ~cfg_port_en[cfg_port];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel_q    <= 1'b0;
      drop_q   <= 1'b0;
      rr_port  <= 1'b0;
      turn_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        sel_q    <= sel_n;
        drop_q   <= drop_n;
        rr_port  <= rr_n;
        turn_cnt <= turn_n;
      end
    end
  end

  // Counters are charged with the decision that steered the frame, i.e. the value before load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames0 <= '0;
      stat_frames1 <= '0;
      stat_drops   <= '0;
    end else if (stat_clear) begin
      stat_frames0 <= '0;
      stat_frames1 <= '0;
      stat_drops   <= '0;
    end else if (frame_done) begin
      if (drop_q) begin
        if (!(&stat_drops)) stat_drops <= stat_drops + 1'b1;
      end else if (sel_q) begin
        if (!(&stat_frames1)) stat_frames1 <= stat_frames1 + 1'b1;
      end else begin
        if (!(&stat_frames0)) stat_frames0 <= stat_frames0 + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_dmux_sched.sv
// tb/tb_axis_dmux_sched.sv - self-checking bench for axis_dmux_sched
// Frame table plus hand sequences; per-beat steering checked against an expectation queue.
module tb_axis_dmux_sched;

  localparam int WW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mon_tvalid, mon_tready, mon_tlast;
  logic          cfg_enable, cfg_mode, cfg_port;
  logic [1:0]    cfg_port_en;
  logic [WW-1:0] cfg_weight0, cfg_weight1;
  logic          stat_clear;
  logic          demux_enable, demux_drop, demux_select, busy;
  logic [CW-1:0] stat_frames0, stat_frames1, stat_drops;

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] exp_q[$];

  axis_dmux_sched #(.WEIGHT_WIDTH(WW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
    .cfg_enable(cfg_enable), .cfg_mode(cfg_mode), .cfg_port(cfg_port),
    .cfg_port_en(cfg_port_en), .cfg_weight0(cfg_weight0), .cfg_weight1(cfg_weight1),
    .stat_clear(stat_clear),
    .demux_enable(demux_enable), .demux_drop(demux_drop), .demux_select(demux_select),
    .busy(busy), .stat_frames0(stat_frames0), .stat_frames1(stat_frames1), .stat_drops(stat_drops)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mode;
    logic       port;
    logic [1:0] en;
    logic [3:0] w0;
    logic [3:0] w1;
    int         nfr;
    int         nbt;
    logic [7:0] selpat;
    logic       drop;
    int         f0;
    int         f1;
    int         dr;
  } vec_t;

  vec_t vt[5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Every accepted beat must carry the steering expected for the frame at the queue head.
  always @(negedge clk) begin
    if (rst_n && mon_tvalid && mon_tready) begin
      if (exp_q.size() == 0) begin
        check("beat_without_expectation", 1, 0);
      end else begin
        check("beat_select", demux_select, exp_q[0][1]);
        check("beat_drop", demux_drop, exp_q[0][0]);
        check("beat_enable", demux_enable, 1);
        if (mon_tlast) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cfg_enable = 1'b0;
    mon_tvalid = 1'b0;
    mon_tlast = 1'b0;
    stat_clear = 1'b0;
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic arm();
    cfg_enable = 1'b1;
    tick();
  endtask

  task automatic send_frame(input int nbt, input logic esel, input logic edrop);
    exp_q.push_back({esel, edrop});
    for (int b = 0; b < nbt; b++) begin
      mon_tvalid = 1'b1;
      mon_tready = 1'b1;
      mon_tlast  = (b == nbt - 1);
      tick();
    end
    mon_tvalid = 1'b0;
    mon_tlast  = 1'b0;
  endtask

  initial begin
    vt[0] = '{mode:1'b0, port:1'b1, en:2'b11, w0:4'd1, w1:4'd1, nfr:3, nbt:4, selpat:8'hFF,       drop:1'b0, f0:0, f1:3, dr:0};
    vt[1] = '{mode:1'b1, port:1'b0, en:2'b11, w0:4'd2, w1:4'd1, nfr:6, nbt:1, selpat:8'b00100100, drop:1'b0, f0:4, f1:2, dr:0};
    vt[2] = '{mode:1'b1, port:1'b1, en:2'b01, w0:4'd2, w1:4'd1, nfr:3, nbt:2, selpat:8'h00,       drop:1'b0, f0:3, f1:0, dr:0};
    vt[3] = '{mode:1'b1, port:1'b0, en:2'b00, w0:4'd2, w1:4'd1, nfr:3, nbt:3, selpat:8'h00,       drop:1'b1, f0:0, f1:0, dr:3};
    vt[4] = '{mode:1'b0, port:1'b0, en:2'b10, w0:4'd1, w1:4'd1, nfr:2, nbt:1, selpat:8'h00,       drop:1'b1, f0:0, f1:0, dr:2};

    mon_tready = 1'b1;
    cfg_mode = 1'b0; cfg_port = 1'b0; cfg_port_en = 2'b11;
    cfg_weight0 = 4'd1; cfg_weight1 = 4'd1;
    do_reset();
    check("reset_enable", demux_enable, 0);
    check("reset_drop", demux_drop, 0);
    check("reset_select", demux_select, 0);
    check("reset_busy", busy, 0);
    check("reset_stats", {stat_frames0, stat_frames1, stat_drops}, 0);

    for (int i = 0; i < 5; i++) begin
      do_reset();
      cfg_mode = vt[i].mode; cfg_port = vt[i].port; cfg_port_en = vt[i].en;
      cfg_weight0 = vt[i].w0; cfg_weight1 = vt[i].w1;
      arm();
      for (int f = 0; f < vt[i].nfr; f++) send_frame(vt[i].nbt, vt[i].selpat[f], vt[i].drop);
      check($sformatf("vec%0d_frames0", i), stat_frames0, vt[i].f0);
      check($sformatf("vec%0d_frames1", i), stat_frames1, vt[i].f1);
      check($sformatf("vec%0d_drops", i), stat_drops, vt[i].dr);
      check($sformatf("vec%0d_pending", i), exp_q.size(), 0);
    end

    // cfg_port flip and disable at beat 2: frame stays on port 0, enable falls after eof
    do_reset();
    cfg_mode = 1'b0; cfg_port = 1'b0; cfg_port_en = 2'b11;
    arm();
    exp_q.push_back(2'b00);
    for (int b = 0; b < 5; b++) begin
      mon_tvalid = 1'b1;
      mon_tlast  = (b == 4);
      if (b == 2) begin
        cfg_port = 1'b1;
        cfg_enable = 1'b0;
      end
      tick();
      if (b == 3) check("midframe_busy", busy, 1);
    end
    mon_tvalid = 1'b0; mon_tlast = 1'b0;
    check("disable_enable_after_eof", demux_enable, 0);
    check("disable_busy_after_eof", busy, 0);
    check("disable_frames0", stat_frames0, 1);
    tick();
    check("disable_stays_idle", demux_enable, 0);

    // reset mid-frame while round-robin is on port 1
    do_reset();
    cfg_mode = 1'b1; cfg_port_en = 2'b11; cfg_weight0 = 4'd1; cfg_weight1 = 4'd1;
    arm();
    send_frame(1, 1'b0, 1'b0);
    exp_q.push_back(2'b10);
    mon_tvalid = 1'b1; mon_tlast = 1'b0;
    tick();
    check("prereset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {demux_enable, demux_drop, demux_select, busy}, 0);
    check("async_reset_stats", {stat_frames0, stat_frames1, stat_drops}, 0);
    exp_q.delete();
    mon_tvalid = 1'b0;
    cfg_enable = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    arm();
    send_frame(2, 1'b0, 1'b0);
    check("post_reset_port0", stat_frames0, 1);

    // drop-counter saturation, then clear beating a same-cycle increment
    do_reset();
    cfg_mode = 1'b1; cfg_port_en = 2'b00; cfg_weight0 = 4'd2; cfg_weight1 = 4'd1;
    arm();
    for (int f = 0; f < 14; f++) send_frame(1, 1'b0, 1'b1);
    check("drops_near_full", stat_drops, 14);
    for (int f = 0; f < 3; f++) send_frame(1, 1'b0, 1'b1);
    check("drops_saturated", stat_drops, 15);
    stat_clear = 1'b1;
    send_frame(1, 1'b0, 1'b1);
    stat_clear = 1'b0;
    check("clear_beats_increment", stat_drops, 0);
    check("clear_frames0", stat_frames0, 0);
    tick();
    check("final_pending", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
